alarm_minigame: RTL
===================

Name: alarm_minigame

Overview:
- Wake-up challenge game that runs after the alarm is acknowledged.
- Consumer of the `minigame_enable` / `minigame_done` handshake raised by the alarm-ringing logic.
- Shows a pseudo-random decimal digit. The user dials it on `guess` and presses `button`.
- `ROUNDS` consecutive correct answers emit a one-cycle `minigame_done` pulse, which closes the handshake.

Parameters:
- ROUNDS, 3, consecutive correct answers required; legal range 1..7.
- TIMEOUT_S, 9, seconds allowed per round, counted with `tick_1hz`; legal range 1..15.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- MCLK  input  1  system clock
- RESET  input  1  asynchronous, active-high reset
- minigame_enable  input  1  level request; a 0->1 edge starts a game
- button  input  1  debounced single-cycle pulse; submits the guess
- guess  input  4  user digit (switches)
- tick_1hz  input  1  single-cycle pulse, once per second
- minigame_done  output  1  one-cycle pulse on game success
- game_active  output  1  high in every state except IDLE
- target_digit  output  4  digit to match, 0..9; 0 in IDLE
- round_cnt  output  3  correct answers so far this game
- time_left  output  4  seconds remaining in the current round
- miss  output  1  one-cycle pulse on a wrong guess or timeout

Behaviour:
- Clock, reset: clock MCLK, reset RESET is asynchronous, active-high; all flops reset.
- Reset values: state=IDLE; minigame_done=0; game_active=0; target_digit=0; round_cnt=0; time_left=0; miss=0; enable_q=0; LFSR=LFSR_SEED.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; shifts every MCLK cycle in all states.
  - Free-running, so user timing adds entropy.
  - Digit mapping from low nibble n: n<=9 gives n; n>9 gives n-6.
- FSM states: IDLE, GEN, WAIT, DONE.
- IDLE:
  - Rising edge of minigame_enable (enable & ~enable_q) -> GEN.
  - A level that is high without an edge does not start a game.
  - round_cnt is cleared on the transition.
- GEN (exactly 1 cycle):
  - Latch mapped digit into target_digit.
  - time_left <= TIMEOUT_S.
  - -> WAIT.
- WAIT, evaluated in priority order:
  1. minigame_enable=0 -> abort to IDLE. No done pulse; outputs return to reset values.
  2. button=1 and guess==target_digit:
     - If round_cnt+1==ROUNDS -> DONE.
     - Else round_cnt+1 -> GEN.
  3. button=1 and guess!=target_digit: miss=1, round_cnt<=0, -> GEN.
  4. tick_1hz=1:
     - time_left==1 -> miss=1, round_cnt<=0, -> GEN (timeout).
     - Else time_left-1.
- Simultaneous button and tick in WAIT: button wins; the tick is dropped.
- guess values 10..15 never match.
- DONE (exactly 1 cycle):
  - minigame_done=1, round_cnt holds ROUNDS.
  - -> IDLE.
  - The requester clears enable on this pulse. A stale high enable in IDLE cannot restart, because restart requires an edge.
- Latency: button in WAIT -> minigame_done high on the next cycle when it was the final round.
- minigame_done and miss are registered and high for exactly one cycle.
- RESET mid-game: immediate IDLE with no done pulse.

Optional Feature:
- Macro: MINIGAME_TIMEOUT_EN.
- Defined:
  - Per-round timeout as described above.
  - time_left counts down from TIMEOUT_S.
- Undefined:
  - tick_1hz is ignored and time_left is held at 0.
  - WAIT leaves only on button or enable drop.
  - Timeout logic is not synthesized.

Decomposition:
- Package alarm_minigame_pkg:
  - state enum (IDLE, GEN, WAIT, DONE);
  - LFSR width 8 and tap mask 8'hB8;
  - digit-mapping constant 6;
  - default seed.
- Sub-module minigame_lfsr:
  - 8-bit LFSR with seed parameter and async reset;
  - outputs the mapped digit 0..9.
- Top FSM, round counter and timer live in alarm_minigame.

Test Plan:
- After reset, raise enable and answer three rounds correctly (guess=target_digit, button pulse) -> round_cnt 1,2,3; minigame_done high exactly one cycle after the third button; game_active=0 the following cycle.
- Two correct answers, then guess=target_digit^1 with button -> miss pulse; round_cnt=0; new target latched; three more correct answers still required.
- With MINIGAME_TIMEOUT_EN and TIMEOUT_S=3, send 3 tick_1hz pulses without button -> time_left 3,2,1, then miss, round_cnt=0, time_left reloads to 3.
- Drop enable in WAIT with round_cnt=2 -> IDLE next cycle; minigame_done never pulses. Hold enable high through DONE -> no restart until enable goes 0 then 1.
- Assert button and tick_1hz in the same cycle with a correct guess -> round_cnt increments, no miss. Assert RESET mid-WAIT -> all outputs at reset values immediately.
- Sample target_digit over 200 GEN events -> always 0..9, every value 0..9 observed at least once.

Source files
------------

// File: rtl/alarm_minigame_pkg.sv
// Shared types and constants for the alarm wake-up minigame.
package alarm_minigame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mg_state_t;

  localparam int          LFSR_W       = 8;
  localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
  localparam logic [3:0]  DIGIT_FOLD   = 4'd6;
  localparam logic [7:0]  DEFAULT_SEED = 8'hA5;

  // Fold a nibble onto 0..9: 10..15 map to 4..9.
  function automatic logic [3:0] map_digit(input logic [3:0] n);
    return (n > 4'd9) ? (n - DIGIT_FOLD) : n;
  endfunction

endpackage

// File: rtl/minigame_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) that presents a decimal digit.
module minigame_lfsr
  import alarm_minigame_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic       MCLK,
  input  logic       RESET,
  output logic [3:0] digit
);

  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] lfsr_next;

  assign lfsr_next = {lfsr_reg[LFSR_W-2:0], ^(lfsr_reg & LFSR_TAPS)};

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign digit = map_digit(lfsr_reg[3:0]);

endmodule

// File: rtl/alarm_minigame.sv
// Wake-up challenge: match ROUNDS pseudo-random digits in a row to finish.
// Per-round timeout is built only when MINIGAME_TIMEOUT_EN is defined.
module alarm_minigame
  import alarm_minigame_pkg::*;
#(
  parameter int          ROUNDS    = 3,
  parameter int          TIMEOUT_S = 9,
  parameter logic [7:0]  LFSR_SEED = DEFAULT_SEED
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       minigame_enable,
  input  logic       button,
  input  logic [3:0] guess,
  input  logic       tick_1hz,
  output logic       minigame_done,
  output logic       game_active,
  output logic [3:0] target_digit,
  output logic [2:0] round_cnt,
  output logic [3:0] time_left,
  output logic       miss
);

  localparam logic [2:0] ROUNDS_C = 3'(ROUNDS);
  localparam logic [2:0] LAST_C   = 3'(ROUNDS - 1);
`ifdef MINIGAME_TIMEOUT_EN
  localparam logic [3:0] TIME_LOAD = 4'(TIMEOUT_S);
`else
  localparam logic [3:0] TIME_LOAD = 4'd0;
  logic unused_tick;
  assign unused_tick = tick_1hz;
`endif

  mg_state_t  state_reg, state_next;
  logic       enable_q;
  logic [3:0] lfsr_digit;
  logic [3:0] target_next;
  logic [2:0] round_next;
  logic [3:0] time_next;
  logic       miss_next;
  logic       done_next;

  minigame_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .MCLK  (MCLK),
    .RESET (RESET),
    .digit (lfsr_digit)
  );

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      enable_q      <= 1'b0;
      target_digit  <= 4'd0;
      round_cnt     <= 3'd0;
      time_left     <= 4'd0;
      miss          <= 1'b0;
      minigame_done <= 1'b0;
    end else begin
      state_reg     <= state_next;
      enable_q      <= minigame_enable;
      target_digit  <= target_next;
      round_cnt     <= round_next;
      time_left     <= time_next;
      miss          <= miss_next;
      minigame_done <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_digit;
    round_next  = round_cnt;
    time_next   = time_left;
    miss_next   = 1'b0;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        target_next = 4'd0;
        time_next   = 4'd0;
        // Only an edge starts a game, so a stale high level after DONE cannot restart it.
        if (minigame_enable && !enable_q) begin
          state_next = GEN;
          round_next = 3'd0;
        end
      end
      GEN: begin
        target_next = lfsr_digit;
        time_next   = TIME_LOAD;
        state_next  = WAIT;
      end
      WAIT: begin
        if (!minigame_enable) begin
          state_next  = IDLE;
          round_next  = 3'd0;
          target_next = 4'd0;
          time_next   = 4'd0;
        end else if (button && (guess == target_digit)) begin
          if (round_cnt == LAST_C) begin
            state_next = DONE;
            round_next = ROUNDS_C;
            done_next  = 1'b1;
          end else begin
            state_next = GEN;
            round_next = round_cnt + 3'd1;
          end
        end else if (button) begin
          state_next = GEN;
          round_next = 3'd0;
          miss_next  = 1'b1;
`ifdef MINIGAME_TIMEOUT_EN
        end else if (tick_1hz) begin
          if (time_left == 4'd1) begin
            state_next = GEN;
            round_next = 3'd0;
            miss_next  = 1'b1;
          end else begin
            time_next = time_left - 4'd1;
          end
`endif
        end
      end
      DONE: begin
        state_next  = IDLE;
        target_next = 4'd0;
        time_next   = 4'd0;
      end
      default: state_next = IDLE;
    endcase
  end

  assign game_active = (state_reg != IDLE);

endmodule
